// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module      : data_cache
// Description : Direct-mapped, write-through, no-write-allocate data cache
//               between the memory pipeline stage and the backing data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 17,
   parameter int SETS       = 256,
   parameter int LINE_WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req_i,
   input  logic                  cpu_we_i,
   input  logic [2:0]            cpu_size_i,
   input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
   input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
   output logic [DATA_WIDTH-1:0] cpu_rdata_o,
   output logic                  cpu_stall_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic [3:0]            mem_wstrb_o,
   input  logic                  mem_ack_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   localparam int c_WORD_BITS  = $clog2(LINE_WORDS);
   localparam int c_INDEX_BITS = $clog2(SETS);
   localparam int c_LINE_LSB   = 2 + c_WORD_BITS;
   localparam int c_TAG_LSB    = c_LINE_LSB + c_INDEX_BITS;
   localparam int c_TAG_BITS   = ADDR_WIDTH - c_TAG_LSB;
   localparam logic [c_WORD_BITS-1:0] c_LAST_BEAT = c_WORD_BITS'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t r_state;
   state_t w_nextState;

   logic [SETS-1:0]       r_valid;
   logic [c_TAG_BITS-1:0] r_tagMem  [SETS];
   logic [DATA_WIDTH-1:0] r_dataMem [SETS*LINE_WORDS];

   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [c_WORD_BITS-1:0] r_beat;
   logic [DATA_WIDTH-1:0]  r_wdata;
   logic [3:0]             r_strb;
   logic                   r_wrHit;

   logic [c_INDEX_BITS-1:0] w_cpuIndex;
   logic [c_WORD_BITS-1:0]  w_cpuWord;
   logic [c_TAG_BITS-1:0]   w_cpuTag;
   logic [c_INDEX_BITS-1:0] w_regIndex;
   logic [c_WORD_BITS-1:0]  w_regWord;
   logic [c_TAG_BITS-1:0]   w_regTag;
   logic                    w_hit;
   logic [3:0]              w_strb;
   logic [DATA_WIDTH-1:0]   w_lane;
   logic                    w_refillAck;
   logic                    w_lastBeat;
   logic                    w_unused;

   assign w_cpuWord  = cpu_addr_i[2 +: c_WORD_BITS];
   assign w_cpuIndex = cpu_addr_i[c_LINE_LSB +: c_INDEX_BITS];
   assign w_cpuTag   = cpu_addr_i[c_TAG_LSB +: c_TAG_BITS];
   assign w_regWord  = r_addr[2 +: c_WORD_BITS];
   assign w_regIndex = r_addr[c_LINE_LSB +: c_INDEX_BITS];
   assign w_regTag   = r_addr[c_TAG_LSB +: c_TAG_BITS];

   assign w_hit       = cpu_req_i & r_valid[w_cpuIndex] & (r_tagMem[w_cpuIndex] == w_cpuTag);
   assign cpu_rdata_o = r_dataMem[{w_cpuIndex, w_cpuWord}];
   assign w_refillAck = (r_state == REFILL) & mem_ack_i;
   assign w_lastBeat  = (r_beat == c_LAST_BEAT);
   assign w_unused    = cpu_size_i[2];

   // Store data is replicated across lanes; the strobe picks the live bytes.
   always_comb begin
      w_strb = 4'b1111;
      w_lane = cpu_wdata_i;
      case (cpu_size_i[1:0])
         2'b00: begin
            w_strb = 4'b0001 << cpu_addr_i[1:0];
            w_lane = {4{cpu_wdata_i[7:0]}};
         end
         2'b01: begin
            w_strb = 4'b0011 << {cpu_addr_i[1], 1'b0};
            w_lane = {2{cpu_wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      cpu_stall_o = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      case (r_state)
         IDLE: begin
            if (cpu_req_i) begin
               if (cpu_we_i) begin
                  cpu_stall_o = 1'b1;
                  w_nextState = WRITE;
               end else if (!w_hit) begin
                  cpu_stall_o = 1'b1;
                  w_nextState = REFILL;
               end
            end
         end
         REFILL: begin
            cpu_stall_o = 1'b1;
            mem_req_o   = 1'b1;
            if (mem_ack_i && w_lastBeat) begin
               w_nextState = IDLE;
            end
         end
         WRITE: begin
            cpu_stall_o = 1'b1;
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            if (mem_ack_i) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   assign mem_addr_o  = (r_state == REFILL) ? {r_addr[ADDR_WIDTH-1:c_LINE_LSB], r_beat, 2'b00} : r_addr;
   assign mem_wdata_o = r_wdata;
   assign mem_wstrb_o = (r_state == WRITE) ? r_strb : 4'b0000;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr  <= '0;
         r_beat  <= '0;
         r_wdata <= '0;
         r_strb  <= '0;
         r_wrHit <= 1'b0;
         r_valid <= '0;
      end else begin
         if (r_state == IDLE && cpu_req_i) begin
            if (cpu_we_i) begin
               r_addr  <= {cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
               r_strb  <= w_strb;
               r_wdata <= w_lane;
               r_wrHit <= w_hit;
            end else if (!w_hit) begin
               r_addr <= {cpu_addr_i[ADDR_WIDTH-1:c_LINE_LSB], {c_LINE_LSB{1'b0}}};
               r_beat <= '0;
            end
         end
         if (w_refillAck) begin
            r_beat <= r_beat + c_WORD_BITS'(1);
            if (w_lastBeat) begin
               r_valid[w_regIndex] <= 1'b1;
            end
         end
      end
   end

   // Arrays carry no reset; the async-reset state keeps them from updating during rst.
   always_ff @(posedge clk) begin
      if (w_refillAck) begin
         r_dataMem[{w_regIndex, r_beat}] <= mem_rdata_i;
         if (w_lastBeat) begin
            r_tagMem[w_regIndex] <= w_regTag;
         end
      end
      if (r_state == WRITE && mem_ack_i && r_wrHit) begin
         for (int b = 0; b < 4; b++) begin
            if (r_strb[b]) begin
               r_dataMem[{w_regIndex, w_regWord}][8*b +: 8] <= r_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// Bench for data_cache: directed vector table, corner sequences, and random
// accesses checked against a word-level memory image and a line-presence model.
module tb_data_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req_i, cpu_we_i;
   logic [2:0]  cpu_size_i;
   logic [16:0] cpu_addr_i;
   logic [31:0] cpu_wdata_i, cpu_rdata_o;
   logic        cpu_stall_o, mem_req_o, mem_we_o, mem_ack_i;
   logic [16:0] mem_addr_o;
   logic [31:0] mem_wdata_o, mem_rdata_i;
   logic [3:0]  mem_wstrb_o;

   data_cache dut (
      .clk(clk), .rst(rst),
      .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_size_i(cpu_size_i),
      .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
      .cpu_stall_o(cpu_stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [31:0] bmem   [int];   // backing memory as written by the DUT
   logic [31:0] refMem [int];   // memory as the store semantics say it should be
   int          lineTag [int];  // index -> tag of the line expected to be resident

   int          waitCyc = 0;
   bit          spurious = 1'b0;
   int          cnt = 0;
   int          nReads, nWrites;
   int          rdAddrQ [$];
   logic [16:0] lastWrAddr;
   logic [31:0] lastWrData;
   logic [3:0]  lastWrStrb;
   int          mwa;
   logic [31:0] mword;

   function automatic logic [31:0] initWord(int wa);
      return 32'h5EED0000 ^ (32'(wa) * 32'h00010019);
   endfunction

   function automatic logic [31:0] bmemRd(int wa);
      return bmem.exists(wa) ? bmem[wa] : initWord(wa);
   endfunction

   function automatic logic [31:0] refRd(int wa);
      return refMem.exists(wa) ? refMem[wa] : initWord(wa);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Backing memory: acks after waitCyc idle cycles of an asserted request.
   always @(negedge clk) begin
      if (mem_req_o === 1'b1) begin
         if (cnt >= waitCyc) begin
            cnt = 0;
            mem_ack_i = 1'b1;
            mwa = int'(mem_addr_o >> 2);
            if (mem_we_o) begin
               nWrites++;
               lastWrAddr = mem_addr_o;
               lastWrData = mem_wdata_o;
               lastWrStrb = mem_wstrb_o;
               mword = bmemRd(mwa);
               for (int b = 0; b < 4; b++)
                  if (mem_wstrb_o[b]) mword[8*b +: 8] = mem_wdata_o[8*b +: 8];
               bmem[mwa] = mword;
               mem_rdata_i = $urandom;
            end else begin
               nReads++;
               rdAddrQ.push_back(int'(mem_addr_o));
               mem_rdata_i = bmemRd(mwa);
            end
         end else begin
            cnt++;
            mem_ack_i = 1'b0;
            mem_rdata_i = $urandom;
         end
      end else begin
         cnt = 0;
         mem_ack_i = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
         mem_rdata_i = $urandom;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the access retires.
   task automatic runAccess(input bit we, input logic [2:0] size, input logic [16:0] addr,
                            input logic [31:0] wdata, input int wt,
                            output int stalls, output logic [31:0] rdata);
      int          wa  = int'(addr >> 2);
      int          idx = int'((addr >> 4) & 17'hFF);
      int          tag = int'(addr >> 12);
      int          base = int'(addr) & ~32'hF;
      bit          expHit, done;
      int          expStall;
      logic [31:0] expWord;
      waitCyc = wt;
      nReads = 0;
      nWrites = 0;
      rdAddrQ.delete();
      expHit = lineTag.exists(idx) && lineTag[idx] == tag;
      expStall = we ? wt + 2 : (expHit ? 0 : 1 + 4 * (wt + 1));
      expWord = refRd(wa);
      if (we) begin
         case (size[1:0])
            2'b00:   expWord[8*addr[1:0] +: 8] = wdata[7:0];
            2'b01:   expWord[16*addr[1] +: 16] = wdata[15:0];
            default: expWord = wdata;
         endcase
         refMem[wa] = expWord;
      end else begin
         lineTag[idx] = tag;
      end
      cpu_req_i = 1'b1;
      cpu_we_i = we;
      cpu_size_i = size;
      cpu_addr_i = addr;
      cpu_wdata_i = wdata;
      stalls = 0;
      done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk);
         #1;
         if (cpu_stall_o !== 1'b1) done = 1'b1;
         else stalls++;
      end
      rdata = cpu_rdata_o;
      @(posedge clk);
      #1;
      cpu_req_i = 1'b0;
      cpu_we_i = 1'b0;
      chk($sformatf("stall@%h", addr), stalls, expStall);
      chk($sformatf("reads@%h", addr), nReads, (we || expHit) ? 0 : 4);
      chk($sformatf("writes@%h", addr), nWrites, we ? 1 : 0);
      if (!we) begin
         chk($sformatf("rdata@%h", addr), rdata, expWord);
         if (!expHit)
            for (int k = 0; k < rdAddrQ.size() && k < 4; k++)
               chk($sformatf("refillAddr%0d@%h", k, addr), rdAddrQ[k], base + 4 * k);
      end else begin
         chk($sformatf("wrAddr@%h", addr), lastWrAddr, addr & ~17'h3);
         chk($sformatf("memImage@%h", addr), bmemRd(wa), expWord);
      end
   endtask

   typedef struct {
      bit          we;
      logic [2:0]  size;
      logic [16:0] addr;
      logic [31:0] wdata;
      int          wt;
      int          expStall;
      logic [31:0] expRdata;
      logic [3:0]  expStrb;
      logic [31:0] expWdata;
   } vec_t;

   vec_t        vecs [16];
   int          st;
   logic [31:0] rd;
   bit          seen;
   int          nIdle;
   logic [16:0] raddr;
   logic [2:0]  rsize;

   initial begin
      vecs[0]  = '{1'b0, 3'b010, 17'h00104, 32'h0,        2, 13, 32'h000000A1, 4'h0, 32'h0};
      vecs[1]  = '{1'b0, 3'b010, 17'h0010C, 32'h0,        2,  0, 32'h000000A3, 4'h0, 32'h0};
      vecs[2]  = '{1'b1, 3'b000, 17'h00105, 32'h0000005A, 2,  4, 32'h0,        4'b0010, 32'h5A5A5A5A};
      vecs[3]  = '{1'b0, 3'b010, 17'h00104, 32'h0,        1,  0, 32'h00005AA1, 4'h0, 32'h0};
      vecs[4]  = '{1'b1, 3'b010, 17'h00200, 32'hDEADBEEF, 2,  4, 32'h0,        4'b1111, 32'hDEADBEEF};
      vecs[5]  = '{1'b0, 3'b010, 17'h00200, 32'h0,        1,  9, 32'hDEADBEEF, 4'h0, 32'h0};
      vecs[6]  = '{1'b0, 3'b010, 17'h00104, 32'h0,        0,  0, 32'h00005AA1, 4'h0, 32'h0};
      vecs[7]  = '{1'b0, 3'b010, 17'h04104, 32'h0,        1,  9, initWord(32'h1041), 4'h0, 32'h0};
      vecs[8]  = '{1'b0, 3'b010, 17'h00104, 32'h0,        1,  9, 32'h00005AA1, 4'h0, 32'h0};
      vecs[9]  = '{1'b1, 3'b001, 17'h0010E, 32'h1234BEEF, 0,  2, 32'h0,        4'b1100, 32'hBEEFBEEF};
      vecs[10] = '{1'b0, 3'b010, 17'h0010C, 32'h0,        0,  0, 32'hBEEF00A3, 4'h0, 32'h0};
      vecs[11] = '{1'b0, 3'b010, 17'h00300, 32'h0,        0,  5, initWord(32'h00C0), 4'h0, 32'h0};
      vecs[12] = '{1'b1, 3'b010, 17'h00300, 32'h11223344, 0,  2, 32'h0,        4'b1111, 32'h11223344};
      vecs[13] = '{1'b0, 3'b010, 17'h00300, 32'h0,        0,  0, 32'h11223344, 4'h0, 32'h0};
      vecs[14] = '{1'b1, 3'b100, 17'h00303, 32'hCAFE0077, 1,  3, 32'h0,        4'b1000, 32'h77777777};
      vecs[15] = '{1'b0, 3'b010, 17'h00300, 32'h0,        0,  0, 32'h77223344, 4'h0, 32'h0};

      for (int k = 0; k < 4; k++) begin
         bmem[32'h40 + k]   = 32'hA0 + 32'(k);
         refMem[32'h40 + k] = 32'hA0 + 32'(k);
      end

      rst = 1'b1;
      cpu_req_i = 1'b0;
      cpu_we_i = 1'b0;
      cpu_size_i = 3'b010;
      cpu_addr_i = '0;
      cpu_wdata_i = '0;
      mem_ack_i = 1'b0;
      mem_rdata_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rstStall", cpu_stall_o, 0);
      chk("rstMemReq", mem_req_o, 0);
      chk("rstMemWe", mem_we_o, 0);
      chk("rstMemAddr", mem_addr_o, 0);
      chk("rstMemStrb", mem_wstrb_o, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         runAccess(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].wt, st, rd);
         chk($sformatf("vec%0d.stall", i), st, vecs[i].expStall);
         if (vecs[i].we) begin
            chk($sformatf("vec%0d.strb", i), lastWrStrb, vecs[i].expStrb);
            chk($sformatf("vec%0d.wdata", i), lastWrData, vecs[i].expWdata);
         end else begin
            chk($sformatf("vec%0d.rdata", i), rd, vecs[i].expRdata);
         end
      end

      // Request withdrawn mid-refill: the line must still be installed.
      waitCyc = 1;
      nReads = 0;
      rdAddrQ.delete();
      cpu_req_i = 1'b1;
      cpu_we_i = 1'b0;
      cpu_size_i = 3'b010;
      cpu_addr_i = 17'h00600;
      @(negedge clk);
      #1;
      @(negedge clk);
      #1;
      cpu_req_i = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         #1;
         if (mem_req_o === 1'b0) seen = 1'b1;
      end
      chk("dropReqIdle", {mem_req_o, cpu_stall_o}, 0);
      chk("dropReqBeats", nReads, 4);
      lineTag[32'h60] = 0;
      @(posedge clk);
      #1;
      runAccess(1'b0, 3'b010, 17'h00608, 32'h0, 1, st, rd);

      // Reset while beat 2 of a refill is outstanding.
      waitCyc = 2;
      nReads = 0;
      cpu_req_i = 1'b1;
      cpu_addr_i = 17'h00700;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         #1;
         if (nReads >= 2) seen = 1'b1;
      end
      @(posedge clk);
      #2;
      chk("preRstReq", mem_req_o, 1);
      rst = 1'b1;
      cpu_req_i = 1'b0;
      #1;
      chk("midRstReq", mem_req_o, 0);
      chk("midRstStall", cpu_stall_o, 0);
      chk("midRstAddr", mem_addr_o, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      lineTag.delete();
      runAccess(1'b0, 3'b010, 17'h00700, 32'h0, 0, st, rd);
      runAccess(1'b0, 3'b010, 17'h00104, 32'h0, 0, st, rd);

      // Random traffic over a few sets and tags to force hits, conflicts and merges.
      spurious = 1'b1;
      for (int n = 0; n < 400; n++) begin
         raddr = 17'(($urandom_range(0, 2) << 12) | ($urandom_range(0, 3) << 4) |
                     ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
         rsize = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
         if (rsize[1:0] == 2'b01) raddr[0] = 1'b0;
         if (rsize[1:0] == 2'b10) raddr[1:0] = 2'b00;
         runAccess($urandom_range(0, 2) == 0, rsize, raddr, $urandom, $urandom_range(0, 2), st, rd);
         nIdle = $urandom_range(0, 1);
         repeat (nIdle) begin
            @(posedge clk);
            #1;
         end
      end
      spurious = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
